// File: rtl/mem_pkg.sv
// Shared memory-stage definitions: access sizes, opcode ranges, lane masks
// and the split-access rule that execute and memory stages must agree on.
package mem_pkg;

    typedef enum logic [1:0] {
        WORD   = 2'd0,
        DOUBLE = 2'd1,
        BYTE   = 2'd2
    } size_t;

    localparam int OP_WORD_LO   = 3;
    localparam int OP_DOUBLE_LO = 6;
    localparam int OP_BYTE_LO   = 9;
    localparam int OP_BYTE_HI   = 11;

    localparam logic [31:0] MASK_WORD   = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK_DOUBLE = 32'h0000_FFFF;
    localparam logic [31:0] MASK_BYTE   = 32'h0000_00FF;

    typedef struct packed {
        logic       valid;
        size_t      size;
        logic [1:0] off;
        logic       second;
        logic [4:0] tgt;
    } stage_t;

    function automatic logic needs_split(size_t size, logic [1:0] off);
        case (size)
            WORD:    return off != 2'd0;
            DOUBLE:  return off == 2'd3;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(size_t size);
        case (size)
            WORD:    return MASK_WORD;
            DOUBLE:  return MASK_DOUBLE;
            default: return MASK_BYTE;
        endcase
    endfunction

    // Load opcodes 3-5 are word, 6-8 double, 9-11 byte.
    function automatic size_t size_of_opcode(logic [3:0] op);
        if (int'(op) >= OP_BYTE_LO && int'(op) <= OP_BYTE_HI)
            return BYTE;
        else if (int'(op) >= OP_DOUBLE_LO)
            return DOUBLE;
        else if (int'(op) >= OP_WORD_LO)
            return WORD;
        else
            return WORD;
    endfunction

endpackage

// File: rtl/load_align_if.sv
// Load request / RAM read / writeback result bundle between execute-side
// logic and the memory-stage load responder.
interface load_align_if;
    logic        req_valid;
    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic        req_second;
    logic [4:0]  req_tgt;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_result;
    logic [4:0]  ld_tgt;
    logic        proto_err;

    modport master (
        output req_valid, req_size, req_off, req_second, req_tgt, mem_rdata,
        input  ld_valid, ld_result, ld_tgt, proto_err
    );

    modport slave (
        input  req_valid, req_size, req_off, req_second, req_tgt, mem_rdata,
        output ld_valid, ld_result, ld_tgt, proto_err
    );
endinterface

// File: rtl/load_lane_merge.sv
// Byte-lane extraction and split-half merge for one RAM read word.
// Purely combinational; shift amounts are 6 bits so a shift of 32 clears.
module load_lane_merge
    import mem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic [31:0] partial,
    input  logic [31:0] rdata,
    input  logic        second,
    output logic [31:0] shifted,
    output logic [31:0] result
);
    logic [5:0]  sh_dn;
    logic [5:0]  sh_up;
    logic [31:0] merged;

    always_comb begin
        sh_dn   = {1'b0, off, 3'b000};
        sh_up   = 6'd32 - sh_dn;
        shifted = rdata >> sh_dn;
        merged  = second ? (partial | (rdata << sh_up)) : shifted;
        result  = merged & size_mask(size);
    end
endmodule

// File: rtl/load_align.sv
// Memory-stage load responder: registers the access, then aligns or merges
// the RAM read word(s) into a zero-extended result for writeback.
//
// state | meaning
// IDLE  | no split pending; next first-half access is handled fresh
// WAIT2 | first half captured in partial, waiting for the second half
module load_align
    import mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic         halt,
    input  logic         flush,
    load_align_if.slave  bus
);
    typedef enum logic {IDLE, WAIT2} state_t;

    logic        adv;
    stage_t      p_q, p_d;
    state_t      state_q, state_d;
    logic [31:0] partial_q, partial_d;
    size_t       sv_size_q, sv_size_d;
    logic [1:0]  sv_off_q, sv_off_d;
    logic [4:0]  sv_tgt_q, sv_tgt_d;

    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_result_q, ld_result_d;
    logic [4:0]  ld_tgt_q, ld_tgt_d;
    logic        proto_q, proto_d;

    logic        m_second;
    size_t       m_size;
    logic [1:0]  m_off;
    logic [31:0] m_shifted;
    logic [31:0] m_result;

    assign adv = clk_en && !halt;

    // Size code 3 is illegal and is captured as no request.
    always_comb begin
        p_d.valid  = bus.req_valid && !flush && (bus.req_size != 2'd3);
        p_d.size   = size_t'(bus.req_size);
        p_d.off    = bus.req_off;
        p_d.second = bus.req_second;
        p_d.tgt    = bus.req_tgt;
    end

    assign m_second = (state_q == WAIT2) && p_q.second;
    assign m_size   = m_second ? sv_size_q : p_q.size;
    assign m_off    = m_second ? sv_off_q  : p_q.off;

    load_lane_merge u_merge (
        .size    (m_size),
        .off     (m_off),
        .partial (partial_q),
        .rdata   (bus.mem_rdata),
        .second  (m_second),
        .shifted (m_shifted),
        .result  (m_result)
    );

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        sv_size_d   = sv_size_q;
        sv_off_d    = sv_off_q;
        sv_tgt_d    = sv_tgt_q;
        ld_valid_d  = 1'b0;
        ld_result_d = '0;
        ld_tgt_d    = '0;
        proto_d     = proto_q;

        if (p_q.valid) begin
            if (p_q.second) begin
                if (state_q == WAIT2) begin
                    ld_valid_d  = 1'b1;
                    ld_result_d = m_result;
                    ld_tgt_d    = sv_tgt_q;
                    state_d     = IDLE;
                    partial_d   = '0;
                end else begin
                    proto_d = 1'b1;
                end
            end else begin
                // An unfinished split is abandoned; the new access still runs.
                if (state_q == WAIT2) begin
                    proto_d   = 1'b1;
                    partial_d = '0;
                    state_d   = IDLE;
                end
                if (needs_split(p_q.size, p_q.off)) begin
                    partial_d = m_shifted;
                    sv_size_d = p_q.size;
                    sv_off_d  = p_q.off;
                    sv_tgt_d  = p_q.tgt;
                    state_d   = WAIT2;
                end else begin
                    ld_valid_d  = 1'b1;
                    ld_result_d = m_result;
                    ld_tgt_d    = p_q.tgt;
                end
            end
        end

        if (flush) begin
            state_d     = IDLE;
            partial_d   = '0;
            ld_valid_d  = 1'b0;
            ld_result_d = '0;
            ld_tgt_d    = '0;
            proto_d     = proto_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            state_q     <= IDLE;
            partial_q   <= '0;
            sv_size_q   <= WORD;
            sv_off_q    <= '0;
            sv_tgt_q    <= '0;
            ld_valid_q  <= 1'b0;
            ld_result_q <= '0;
            ld_tgt_q    <= '0;
            proto_q     <= 1'b0;
        end else if (adv) begin
            p_q         <= p_d;
            state_q     <= state_d;
            partial_q   <= partial_d;
            sv_size_q   <= sv_size_d;
            sv_off_q    <= sv_off_d;
            sv_tgt_q    <= sv_tgt_d;
            ld_valid_q  <= ld_valid_d;
            ld_result_q <= ld_result_d;
            ld_tgt_q    <= ld_tgt_d;
            proto_q     <= proto_d;
        end
    end

    assign bus.ld_valid  = ld_valid_q;
    assign bus.ld_result = ld_result_q;
    assign bus.ld_tgt    = ld_tgt_q;
    assign bus.proto_err = proto_q;
endmodule

// File: tb/tb_load_align.sv
// Self-checking bench for load_align: directed vector table, hand-written
// corner sequences, then random traffic against a byte-queue reference model.
module tb_load_align;
    logic clk;
    logic rst_n;
    logic clk_en;
    logic halt;
    logic flush;

    load_align_if lif();

    load_align dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .halt   (halt),
        .flush  (flush),
        .bus    (lif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        logic [1:0]  size;
        logic [1:0]  off;
        logic [31:0] w0;
        logic [31:0] w1;
        int          bubbles;
        logic        split;
        logic [4:0]  tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    // reference model state
    logic        e_valid;
    logic [31:0] e_result;
    logic [4:0]  e_tgt;
    logic        e_proto;
    logic        mp_valid;
    logic [1:0]  mp_size;
    logic [1:0]  mp_off;
    logic        mp_second;
    logic [4:0]  mp_tgt;
    logic        pend;
    int          pend_need;
    logic [4:0]  pend_tgt;
    logic [7:0]  pq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] sz, input logic [1:0] off,
                        input logic sec, input logic [4:0] tgt, input logic [31:0] rd);
        @(negedge clk);
        flush          = 1'b0;
        lif.req_valid  = v;
        lif.req_size   = sz;
        lif.req_off    = off;
        lif.req_second = sec;
        lif.req_tgt    = tgt;
        lif.mem_rdata  = rd;
    endtask

    task automatic idle(input logic [31:0] rd);
        step(1'b0, 2'd0, 2'd0, 1'b0, 5'd0, rd);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        step(1'b1, v.size, v.off, 1'b0, v.tgt, $urandom);
        if (!v.split) begin
            idle(v.w0);
        end else begin
            for (int b = 0; b < v.bubbles; b++) begin
                idle((b == 0) ? v.w0 : $urandom);
                chk($sformatf("vec%0d_gap_valid", idx), 32'(lif.ld_valid), 32'd0);
            end
            step(1'b1, v.size, v.off, 1'b1, v.tgt ^ 5'h1F, (v.bubbles == 0) ? v.w0 : $urandom);
            idle(v.w1);
            chk($sformatf("vec%0d_mid_valid", idx), 32'(lif.ld_valid), 32'd0);
        end
        idle($urandom);
        chk($sformatf("vec%0d_valid", idx), 32'(lif.ld_valid), 32'd1);
        chk($sformatf("vec%0d_result", idx), lif.ld_result, v.exp);
        chk($sformatf("vec%0d_tgt", idx), 32'(lif.ld_tgt), 32'(v.tgt));
        idle($urandom);
        chk($sformatf("vec%0d_drop_valid", idx), 32'(lif.ld_valid), 32'd0);
        chk($sformatf("vec%0d_drop_tgt", idx), 32'(lif.ld_tgt), 32'd0);
    endtask

    function automatic int need_of(logic [1:0] sz);
        case (sz)
            2'd0:    return 4;
            2'd1:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] assemble(int need);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < need; i++) r |= 32'(pq[i]) << (8 * i);
        return r;
    endfunction

    task automatic model_reset();
        e_valid = 0; e_result = '0; e_tgt = '0; e_proto = 0;
        mp_valid = 0; mp_size = '0; mp_off = '0; mp_second = 0; mp_tgt = '0;
        pend = 0; pend_need = 0; pend_tgt = '0;
        pq.delete();
    endtask

    task automatic model_step();
        logic        nv;
        logic [31:0] nr;
        logic [4:0]  nt;
        int          need;
        if (!(clk_en && !halt)) return;
        nv = 0; nr = '0; nt = '0;
        if (mp_valid && !flush) begin
            if (mp_second) begin
                if (pend) begin
                    for (int k = 0; k < 4; k++)
                        if (pq.size() < pend_need) pq.push_back(lif.mem_rdata[8*k +: 8]);
                    nv = 1; nr = assemble(pend_need); nt = pend_tgt;
                    pend = 0; pq.delete();
                end else begin
                    e_proto = 1;
                end
            end else begin
                if (pend) begin
                    e_proto = 1; pend = 0; pq.delete();
                end
                for (int k = int'(mp_off); k < 4; k++) pq.push_back(lif.mem_rdata[8*k +: 8]);
                need = need_of(mp_size);
                if (pq.size() >= need) begin
                    nv = 1; nr = assemble(need); nt = mp_tgt; pq.delete();
                end else begin
                    pend = 1; pend_need = need; pend_tgt = mp_tgt;
                end
            end
        end
        if (flush) begin
            pend = 0; pq.delete();
        end
        e_valid = nv; e_result = nr; e_tgt = nt;
        mp_valid  = lif.req_valid && (lif.req_size != 2'd3) && !flush;
        mp_size   = lif.req_size;
        mp_off    = lif.req_off;
        mp_second = lif.req_second;
        mp_tgt    = lif.req_tgt;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; clk_en = 1'b1; halt = 1'b0; flush = 1'b0;
        lif.req_valid = 0; lif.req_size = 0; lif.req_off = 0;
        lif.req_second = 0; lif.req_tgt = 0; lif.mem_rdata = 0;

        vecs[0] = '{2'd0, 2'd0, 32'hDDCCBBAA, 32'h0,        0, 1'b0, 5'd5,  32'hDDCCBBAA};
        vecs[1] = '{2'd2, 2'd2, 32'hDDCCBBAA, 32'h0,        0, 1'b0, 5'd7,  32'h000000CC};
        vecs[2] = '{2'd1, 2'd1, 32'hDDCCBBAA, 32'h0,        0, 1'b0, 5'd9,  32'h0000CCBB};
        vecs[3] = '{2'd0, 2'd1, 32'h44332211, 32'h88776655, 2, 1'b1, 5'd3,  32'h55443322};
        vecs[4] = '{2'd1, 2'd3, 32'h44332211, 32'h88776655, 0, 1'b1, 5'd12, 32'h00005544};
        vecs[5] = '{2'd1, 2'd2, 32'h44332211, 32'h0,        0, 1'b0, 5'd31, 32'h00004433};
        vecs[6] = '{2'd2, 2'd3, 32'hDDCCBBAA, 32'h0,        0, 1'b0, 5'd1,  32'h000000DD};
        vecs[7] = '{2'd0, 2'd3, 32'h44332211, 32'h88776655, 1, 1'b1, 5'd17, 32'h77665544};
        vecs[8] = '{2'd0, 2'd2, 32'h44332211, 32'h88776655, 0, 1'b1, 5'd2,  32'h66554433};

        repeat (2) @(negedge clk);
        chk("rst_valid",  32'(lif.ld_valid),  32'd0);
        chk("rst_result", lif.ld_result,      32'd0);
        chk("rst_tgt",    32'(lif.ld_tgt),    32'd0);
        chk("rst_proto",  32'(lif.proto_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // outputs hold while clk_en is low or halt is high
        step(1'b1, 2'd0, 2'd0, 1'b0, 5'd11, $urandom);
        idle(32'h12345678);
        idle(32'h12345678);
        chk("hold_valid0", 32'(lif.ld_valid), 32'd1);
        clk_en = 1'b0;
        @(negedge clk);
        chk("hold_cken_valid",  32'(lif.ld_valid), 32'd1);
        chk("hold_cken_result", lif.ld_result, 32'h12345678);
        clk_en = 1'b1; halt = 1'b1;
        @(negedge clk);
        chk("hold_halt_tgt", 32'(lif.ld_tgt), 32'd11);
        halt = 1'b0;
        @(negedge clk);
        chk("hold_release_valid", 32'(lif.ld_valid), 32'd0);

        // flush between halves of a split word
        step(1'b1, 2'd0, 2'd1, 1'b0, 5'd4, $urandom);
        step(1'b1, 2'd0, 2'd1, 1'b1, 5'd4, 32'h44332211);
        flush = 1'b1;
        idle(32'h88776655);
        chk("flush_valid_a", 32'(lif.ld_valid), 32'd0);
        step(1'b1, 2'd0, 2'd0, 1'b0, 5'd6, $urandom);
        chk("flush_valid_b", 32'(lif.ld_valid), 32'd0);
        idle(32'hCAFEF00D);
        chk("flush_valid_c", 32'(lif.ld_valid), 32'd0);
        idle($urandom);
        chk("post_flush_valid",  32'(lif.ld_valid), 32'd1);
        chk("post_flush_result", lif.ld_result, 32'hCAFEF00D);
        chk("post_flush_tgt",    32'(lif.ld_tgt), 32'd6);
        chk("post_flush_proto",  32'(lif.proto_err), 32'd0);

        // orphan second half, then reset in the middle of a split
        step(1'b1, 2'd0, 2'd1, 1'b1, 5'd8, $urandom);
        idle($urandom);
        idle($urandom);
        chk("orphan_proto", 32'(lif.proto_err), 32'd1);
        chk("orphan_valid", 32'(lif.ld_valid), 32'd0);
        step(1'b1, 2'd0, 2'd1, 1'b0, 5'd9, $urandom);
        idle(32'h44332211);
        idle($urandom);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid",  32'(lif.ld_valid),  32'd0);
        chk("midrst_result", lif.ld_result,      32'd0);
        chk("midrst_tgt",    32'(lif.ld_tgt),    32'd0);
        chk("midrst_proto",  32'(lif.proto_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd0, 2'd1, 1'b1, 5'd10, $urandom);
        idle(32'h88776655);
        idle($urandom);
        chk("postrst_valid", 32'(lif.ld_valid), 32'd0);
        chk("postrst_proto", 32'(lif.proto_err), 32'd1);

        // random traffic against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd_valid", 32'(lif.ld_valid),  32'(e_valid));
            chk("rnd_tgt",   32'(lif.ld_tgt),    32'(e_tgt));
            chk("rnd_proto", 32'(lif.proto_err), 32'(e_proto));
            if (e_valid) chk("rnd_result", lif.ld_result, e_result);
            clk_en         = ($urandom % 8) != 0;
            halt           = ($urandom % 16) == 0;
            flush          = ($urandom % 16) == 0;
            lif.req_valid  = ($urandom % 3) != 0;
            lif.req_size   = (($urandom % 10) == 0) ? 2'd3 : 2'($urandom % 3);
            lif.req_off    = 2'($urandom);
            lif.req_second = pend ? (($urandom % 4) != 0) : (($urandom % 10) == 0);
            lif.req_tgt    = 5'($urandom);
            lif.mem_rdata  = $urandom;
            model_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
